// File: rtl/fetch_target_queue.sv
// Fetch target queue: circular buffer of predicted fetch blocks between the uBTB and the fetch unit.
// Latency: an enqueued block is presented to fetch the next cycle; the commit-side uBTB update is registered (1 cycle).
// Backpressure: o_enq_rdy drops when DEPTH blocks are live or a squash is in progress. FTQ_BYPASS_EN lets an empty queue present the incoming block in the same cycle.

package fetch_target_queue_pkg;
   localparam int XLEN = 32;

   typedef struct packed {
      logic            hit;
      logic            taken;
      logic [XLEN-1:0] fallthruAddr;
      logic [XLEN-1:0] targetAddr;
      logic [XLEN-1:0] nextAddr;
      logic [1:0]      branch_type;
   } uBTBInfo_t;
endpackage

module fetch_target_queue
   import fetch_target_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_enq_vld,
   output logic                     o_enq_rdy,
   input  logic [XLEN-1:0]          i_enq_startAddr,
   input  uBTBInfo_t                i_enq_info,
   output logic [$clog2(DEPTH)-1:0] o_enq_idx,
   output logic                     o_fetch_vld,
   input  logic                     i_fetch_rdy,
   output logic [XLEN-1:0]          o_fetch_startAddr,
   output logic [XLEN-1:0]          o_fetch_endAddr,
   output logic [$clog2(DEPTH)-1:0] o_fetch_idx,
   input  logic                     i_squash,
   input  logic [$clog2(DEPTH)-1:0] i_squash_idx,
   input  uBTBInfo_t                i_squash_info,
   input  logic                     i_commit,
   output logic                     o_update,
   output logic [XLEN-1:0]          o_update_pc,
   output uBTBInfo_t                o_updateInfo
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   logic [PW-1:0]   r_enq_ptr;
   logic [PW-1:0]   r_fetch_ptr;
   logic [PW-1:0]   r_commit_ptr;

   logic [XLEN-1:0] r_start [DEPTH];
   uBTBInfo_t       r_info  [DEPTH];

   logic            r_upd_vld;
   logic [XLEN-1:0] r_upd_pc;
   uBTBInfo_t       r_upd_info;

   logic [PW-1:0]   w_count;
   logic            w_full;
   logic            w_q_empty;
   logic            w_enq_fire;
   logic            w_fetch_fire;
   logic            w_commit_ok;
   logic [IW-1:0]   w_enq_slot;
   logic [IW-1:0]   w_fetch_slot;
   logic [IW-1:0]   w_commit_slot;
   logic            w_sq_wrap;
   logic [PW-1:0]   w_sq_ptr;
   logic            w_byp;

   assign w_enq_slot    = r_enq_ptr[IW-1:0];
   assign w_fetch_slot  = r_fetch_ptr[IW-1:0];
   assign w_commit_slot = r_commit_ptr[IW-1:0];

   assign w_count    = r_enq_ptr - r_commit_ptr;
   assign w_full     = (w_count == PW'(DEPTH));
   assign w_q_empty  = (r_fetch_ptr == r_enq_ptr);
   assign o_enq_rdy  = !w_full && !i_squash;
   assign w_enq_fire = i_enq_vld && o_enq_rdy;
   assign o_enq_idx  = w_enq_slot;

   // A squash slot at or above the commit slot lies in the commit pointer's lap; below it, in the next lap.
   assign w_sq_wrap = (i_squash_idx >= w_commit_slot) ? r_commit_ptr[IW] : ~r_commit_ptr[IW];
   assign w_sq_ptr  = {w_sq_wrap, i_squash_idx} + PW'(1);

   assign w_commit_ok = i_commit && (r_commit_ptr != r_fetch_ptr);

   // Fetch-side presentation, optionally bypassing the array when the queue is empty.
   always_comb begin
      w_byp             = 1'b0;
      o_fetch_vld       = !w_q_empty;
      o_fetch_startAddr = r_start[w_fetch_slot];
      o_fetch_endAddr   = r_info[w_fetch_slot].fallthruAddr;
`ifdef FTQ_BYPASS_EN
      w_byp = w_q_empty && w_enq_fire;
      if (w_byp) begin
         o_fetch_vld       = 1'b1;
         o_fetch_startAddr = i_enq_startAddr;
         o_fetch_endAddr   = i_enq_info.fallthruAddr;
      end
`endif
   end

   assign o_fetch_idx  = w_fetch_slot;
   // A squash repositions fetch_ptr, so a same-cycle fetch handshake is void.
   assign w_fetch_fire = o_fetch_vld && i_fetch_rdy && !i_squash;

   // Pointer updates; squash overrides enqueue/fetch but commit proceeds independently.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_enq_ptr    <= '0;
         r_fetch_ptr  <= '0;
         r_commit_ptr <= '0;
      end else begin
         if (i_squash) begin
            r_enq_ptr   <= w_sq_ptr;
            r_fetch_ptr <= w_sq_ptr;
         end else begin
            if (w_enq_fire)
               r_enq_ptr <= r_enq_ptr + PW'(1);
            if (w_fetch_fire)
               r_fetch_ptr <= r_fetch_ptr + PW'(1);
         end
         if (w_commit_ok)
            r_commit_ptr <= r_commit_ptr + PW'(1);
      end
   end

   // Entry storage: enqueue writes a new block, squash corrects the mispredicted block's info.
   always_ff @(posedge clk) begin
      if (w_enq_fire) begin
         r_start[w_enq_slot] <= i_enq_startAddr;
         r_info[w_enq_slot]  <= i_enq_info;
      end
      if (i_squash)
         r_info[i_squash_idx] <= i_squash_info;
   end

   // Registered uBTB training pulse for the retired block, forwarding a same-cycle squash correction.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_upd_vld  <= 1'b0;
         r_upd_pc   <= '0;
         r_upd_info <= '0;
      end else begin
         r_upd_vld <= w_commit_ok;
         if (w_commit_ok) begin
            r_upd_pc   <= r_start[w_commit_slot];
            r_upd_info <= (i_squash && (i_squash_idx == w_commit_slot)) ? i_squash_info
                                                                         : r_info[w_commit_slot];
         end
      end
   end

   assign o_update     = r_upd_vld;
   assign o_update_pc  = r_upd_pc;
   assign o_updateInfo = r_upd_info;

endmodule

// File: tb/tb_fetch_target_queue.sv
// Directed bench for fetch_target_queue: fill/full, wrap, squash, commit/update, reset.
// Expected values are hand-derived from the block's behaviour.
// Inputs are driven 1ns after the rising edge; outputs are sampled 1ns after inputs settle.

module tb_fetch_target_queue;
   import fetch_target_queue_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            i_enq_vld;
   logic            o_enq_rdy;
   logic [XLEN-1:0] i_enq_startAddr;
   uBTBInfo_t       i_enq_info;
   logic [2:0]      o_enq_idx;
   logic            o_fetch_vld;
   logic            i_fetch_rdy;
   logic [XLEN-1:0] o_fetch_startAddr;
   logic [XLEN-1:0] o_fetch_endAddr;
   logic [2:0]      o_fetch_idx;
   logic            i_squash;
   logic [2:0]      i_squash_idx;
   uBTBInfo_t       i_squash_info;
   logic            i_commit;
   logic            o_update;
   logic [XLEN-1:0] o_update_pc;
   uBTBInfo_t       o_updateInfo;

   int n_total = 0;
   int n_bad   = 0;

   fetch_target_queue #(.DEPTH(8)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_enq_vld         (i_enq_vld),
      .o_enq_rdy         (o_enq_rdy),
      .i_enq_startAddr   (i_enq_startAddr),
      .i_enq_info        (i_enq_info),
      .o_enq_idx         (o_enq_idx),
      .o_fetch_vld       (o_fetch_vld),
      .i_fetch_rdy       (i_fetch_rdy),
      .o_fetch_startAddr (o_fetch_startAddr),
      .o_fetch_endAddr   (o_fetch_endAddr),
      .o_fetch_idx       (o_fetch_idx),
      .i_squash          (i_squash),
      .i_squash_idx      (i_squash_idx),
      .i_squash_info     (i_squash_info),
      .i_commit          (i_commit),
      .o_update          (o_update),
      .o_update_pc       (o_update_pc),
      .o_updateInfo      (o_updateInfo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic uBTBInfo_t mkinfo(input logic [XLEN-1:0] s);
      uBTBInfo_t v;
      v              = '0;
      v.hit          = 1'b1;
      v.fallthruAddr = s + 32'h10;
      v.nextAddr     = s + 32'h10;
      return v;
   endfunction

   task automatic offer(input logic [XLEN-1:0] s);
      i_enq_vld       = 1'b1;
      i_enq_startAddr = s;
      i_enq_info      = mkinfo(s);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      uBTBInfo_t sq;
      logic      byp_exp;
`ifdef FTQ_BYPASS_EN
      byp_exp = 1'b1;
`else
      byp_exp = 1'b0;
`endif
      rst = 1'b1; i_enq_vld = 0; i_enq_startAddr = '0; i_enq_info = '0;
      i_fetch_rdy = 0; i_squash = 0; i_squash_idx = '0; i_squash_info = '0; i_commit = 0;
      step();
      do_reset();
      #1;
      chk("rst_enq_rdy",   o_enq_rdy,   1);
      chk("rst_fetch_vld", o_fetch_vld, 0);
      chk("rst_update",    o_update,    0);
      chk("rst_enq_idx",   o_enq_idx,   0);
      chk("rst_fetch_idx", o_fetch_idx, 0);

      // Fill eight entries without fetching; slot index walks 0..7.
      for (int i = 0; i < 8; i++) begin
         offer(32'h1000 + 32'(i) * 32'h10);
         #1;
         chk("fill_idx", o_enq_idx, 64'(i));
         chk("fill_rdy", o_enq_rdy, 1);
         if (i == 0) chk("first_same_cycle_vld", o_fetch_vld, byp_exp);
         step();
         if (i == 0) begin
            chk("first_next_vld",  o_fetch_vld,       1);
            chk("first_next_addr", o_fetch_startAddr, 32'h1000);
         end
      end
      offer(32'h1080);
      #1;
      chk("full_rdy",       o_enq_rdy,         0);
      chk("full_fetch_vld", o_fetch_vld,       1);
      chk("full_fetch_end", o_fetch_endAddr,   32'h1010);
      step();
      chk("ninth_held_idx", o_enq_idx, 0);
      chk("ninth_held_rdy", o_enq_rdy, 0);

      // Full with fetch: fetch advances, enqueue stays blocked.
      i_fetch_rdy = 1;
      step();
      chk("full_fetch_idx", o_fetch_idx, 1);
      chk("full_still_rdy", o_enq_rdy,   0);
      chk("full_enq_idx",   o_enq_idx,   0);

      // Commit slot 0, then a commit with nothing fetched beyond it.
      i_enq_vld = 0; i_fetch_rdy = 0; i_commit = 1;
      step();
      chk("c0_update", o_update,                  1);
      chk("c0_pc",     o_update_pc,               32'h1000);
      chk("c0_ft",     o_updateInfo.fallthruAddr, 32'h1010);
      chk("c0_rdy",    o_enq_rdy,                 1);
      step();
      chk("c_idle_update", o_update, 0);
      i_commit = 0;
      i_fetch_rdy = 1;
      step();
      // Simultaneous enqueue (wraps into slot 0), fetch of slot 2 and commit of slot 1.
      offer(32'h3000); i_commit = 1;
      #1;
      chk("tri_fetch_addr", o_fetch_startAddr, 32'h1020);
      step();
      chk("tri_update",    o_update,    1);
      chk("tri_pc",        o_update_pc, 32'h1010);
      chk("tri_fetch_idx", o_fetch_idx, 3);
      chk("tri_enq_idx",   o_enq_idx,   1);
      i_enq_vld = 0; i_commit = 0;
      for (int i = 0; i < 5; i++) step();
      chk("wrap_fetch_idx",  o_fetch_idx,       0);
      chk("wrap_fetch_addr", o_fetch_startAddr, 32'h3000);
      chk("wrap_fetch_vld",  o_fetch_vld,       1);
      i_fetch_rdy = 0;

      // Squash scenario: five blocks fetched, redirect at slot 2.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         offer(32'h4000 + 32'(i) * 32'h10);
         step();
      end
      i_enq_vld = 0; i_fetch_rdy = 1;
      for (int i = 0; i < 5; i++) step();
      i_fetch_rdy = 0;
      #1;
      chk("sq_pre_vld", o_fetch_vld, 0);
      sq = mkinfo(32'h4020); sq.taken = 1; sq.targetAddr = 32'h2000;
      i_squash = 1; i_squash_idx = 3'd2; i_squash_info = sq; offer(32'h9000);
      #1;
      chk("sq_enq_rdy", o_enq_rdy, 0);
      step();
      i_squash = 0; i_enq_vld = 0;
      #1;
      chk("sq_enq_idx",   o_enq_idx,   3);
      chk("sq_fetch_idx", o_fetch_idx, 3);
      chk("sq_fetch_vld", o_fetch_vld, 0);
      i_commit = 1;
      step();
      chk("sq_c0_pc",    o_update_pc,        32'h4000);
      chk("sq_c0_taken", o_updateInfo.taken, 0);
      step();
      chk("sq_c1_pc", o_update_pc, 32'h4010);
      step();
      chk("sq_c2_update", o_update,                1);
      chk("sq_c2_pc",     o_update_pc,             32'h4020);
      chk("sq_c2_taken",  o_updateInfo.taken,      1);
      chk("sq_c2_tgt",    o_updateInfo.targetAddr, 32'h2000);
      step();
      chk("sq_c3_none", o_update, 0);
      i_commit = 0;

      // Squash of the very slot being committed in the same cycle.
      offer(32'h5000); step();
      offer(32'h5010); step();
      i_enq_vld = 0; i_fetch_rdy = 1;
      step(); step();
      i_fetch_rdy = 0;
      sq = mkinfo(32'h5000); sq.taken = 1; sq.targetAddr = 32'h6000;
      i_squash = 1; i_squash_idx = 3'd3; i_squash_info = sq; i_commit = 1;
      step();
      i_squash = 0; i_commit = 0;
      #1;
      chk("sqc_update",    o_update,                1);
      chk("sqc_pc",        o_update_pc,             32'h5000);
      chk("sqc_tgt",       o_updateInfo.targetAddr, 32'h6000);
      chk("sqc_enq_idx",   o_enq_idx,               4);
      chk("sqc_fetch_idx", o_fetch_idx,             4);

      // Reset with live entries and a same-cycle commit.
      for (int i = 0; i < 4; i++) begin
         offer(32'h7000 + 32'(i) * 32'h10);
         step();
      end
      i_enq_vld = 0; i_fetch_rdy = 1;
      step();
      i_fetch_rdy = 0; i_commit = 1; rst = 1;
      step();
      rst = 0; i_commit = 0;
      #1;
      chk("rst2_enq_rdy",   o_enq_rdy,   1);
      chk("rst2_fetch_vld", o_fetch_vld, 0);
      chk("rst2_update",    o_update,    0);
      chk("rst2_enq_idx",   o_enq_idx,   0);
      chk("rst2_fetch_idx", o_fetch_idx, 0);
      step();
      chk("rst2_update_after", o_update, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
